// File: rtl/exc_ctrl.sv
// Exception/interrupt front-end: irq sync + pending latch, cause arbitration,
// single-cycle take/eret pulses to cp0 with pipeline flush and PC redirect.
module exc_ctrl #(
  parameter int unsigned NIRQ        = 6,
  parameter logic [31:0] VECTOR      = 32'h00400004,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [31:0]     pc,
  input  logic            is_syscall,
  input  logic            is_break,
  input  logic            is_teq,
  input  logic            teq_eq,
  input  logic            is_eret,
  input  logic [NIRQ-1:0] irq,
  input  logic [31:0]     status,
  input  logic [31:0]     epc_in,
  output logic            exc_req,
  output logic [4:0]      exc_code,
  output logic [31:0]     exc_epc,
  output logic            eret_req,
  output logic            flush,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            in_handler,
  output logic [NIRQ-1:0] irq_pending
);

  localparam int unsigned CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_INT = 5'b00000;
  localparam logic [CODE_W-1:0] CODE_SYS = 5'b01000;
  localparam logic [CODE_W-1:0] CODE_BP  = 5'b01001;
  localparam logic [CODE_W-1:0] CODE_TR  = 5'b01101;

  typedef enum logic [1:0] {IDLE, TAKE, HANDLER, RET} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q;
  logic [NIRQ-1:0] sync_prev, rise, clr, irq_hit, irq_sel, take_irq, take_irq_d;
  logic            irq_found, cand_valid, take_ok;
  logic [CODE_W-1:0] cand_code, code_d;
  logic [31:0]     epc_d, rpc_d;
  logic            exc_req_d, eret_req_d, flush_d, redirect_d, in_handler_d;

  logic unused_status;
  assign unused_status = ^{status[31:8+NIRQ], status[7:4]};

  assign rise    = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign irq_hit = irq_pending & status[8 +: NIRQ];
  assign take_ok = inst_valid & status[0];

  // Lowest-index enabled pending interrupt wins
  always_comb begin
    irq_sel   = '0;
    irq_found = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (irq_hit[i] && !irq_found) begin
        irq_sel[i] = 1'b1;
        irq_found  = 1'b1;
      end
    end
  end

  // Synchronous causes outrank interrupts
  always_comb begin
    cand_valid = 1'b1;
    cand_code  = CODE_INT;
    if (is_syscall && status[1])              cand_code = CODE_SYS;
    else if (is_break && status[2])           cand_code = CODE_BP;
    else if (is_teq && teq_eq && status[3])   cand_code = CODE_TR;
    else if (irq_found)                       cand_code = CODE_INT;
    else                                      cand_valid = 1'b0;
  end

  always_comb begin
    state_d      = state;
    code_d       = exc_code;
    epc_d        = exc_epc;
    rpc_d        = redirect_pc;
    take_irq_d   = take_irq;
    clr          = '0;
    exc_req_d    = 1'b0;
    eret_req_d   = 1'b0;
    flush_d      = 1'b0;
    redirect_d   = 1'b0;
    in_handler_d = 1'b0;
    case (state)
      IDLE: begin
        if (take_ok && cand_valid) begin
          state_d      = TAKE;
          code_d       = cand_code;
          epc_d        = pc;
          take_irq_d   = (cand_code == CODE_INT) ? irq_sel : '0;
          exc_req_d    = 1'b1;
          flush_d      = 1'b1;
          redirect_d   = 1'b1;
          rpc_d        = VECTOR;
          in_handler_d = 1'b1;
        end
      end
      TAKE: begin
        state_d      = HANDLER;
        clr          = take_irq;
        in_handler_d = 1'b1;
      end
      HANDLER: begin
        in_handler_d = 1'b1;
        if (is_eret && inst_valid) begin
          state_d    = RET;
          eret_req_d = 1'b1;
          flush_d    = 1'b1;
          redirect_d = 1'b1;
          rpc_d      = epc_in;
        end
      end
      RET: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sync_q      <= '0;
      sync_prev   <= '0;
      irq_pending <= '0;
      take_irq    <= '0;
      exc_req     <= 1'b0;
      exc_code    <= '0;
      exc_epc     <= '0;
      eret_req    <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      in_handler  <= 1'b0;
    end else begin
      state       <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], irq};
      sync_prev   <= sync_q[SYNC_STAGES-1];
      // A new edge in the same cycle as its clear keeps the bit set
      irq_pending <= (irq_pending & ~clr) | rise;
      take_irq    <= take_irq_d;
      exc_req     <= exc_req_d;
      exc_code    <= code_d;
      exc_epc     <= epc_d;
      eret_req    <= eret_req_d;
      flush       <= flush_d;
      redirect    <= redirect_d;
      redirect_pc <= rpc_d;
      in_handler  <= in_handler_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  localparam int unsigned NIRQ = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_valid;
  logic [31:0]     pc;
  logic            is_syscall, is_break, is_teq, teq_eq, is_eret;
  logic [NIRQ-1:0] irq;
  logic [31:0]     status, epc_in;
  logic            exc_req, eret_req, flush, redirect, in_handler;
  logic [4:0]      exc_code;
  logic [31:0]     exc_epc, redirect_pc;
  logic [NIRQ-1:0] irq_pending;

  int total = 0;
  int bad   = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc),
    .is_syscall(is_syscall), .is_break(is_break), .is_teq(is_teq),
    .teq_eq(teq_eq), .is_eret(is_eret), .irq(irq), .status(status),
    .epc_in(epc_in), .exc_req(exc_req), .exc_code(exc_code),
    .exc_epc(exc_epc), .eret_req(eret_req), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .in_handler(in_handler), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    is_syscall = 1'b0; is_break = 1'b0; is_teq = 1'b0; teq_eq = 1'b0; is_eret = 1'b0;
  endtask

  // Caller is in HANDLER; leaves the DUT in IDLE
  task automatic do_eret(input string tag, input logic [31:0] target);
    epc_in  = target;
    is_eret = 1'b1;
    tick();
    chk({tag, "_eret_req"}, 32'(eret_req), 32'd1);
    chk({tag, "_eret_pc"}, redirect_pc, target);
    is_eret = 1'b0;
    tick();
    chk({tag, "_ret_idle"}, 32'(in_handler), 32'd0);
  endtask

  initial begin
    rst = 1'b0; inst_valid = 1'b0; pc = '0; irq = '0; status = '0; epc_in = '0;
    clr_dec();
    #3;
    chk("rst_exc_req", 32'(exc_req), 32'd0);
    chk("rst_in_handler", 32'(in_handler), 32'd0);
    chk("rst_pending", 32'(irq_pending), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // syscall take and eret
    status = 32'h3; pc = 32'h00400100; inst_valid = 1'b1; is_syscall = 1'b1;
    tick();
    chk("sys_exc_req", 32'(exc_req), 32'd1);
    chk("sys_code", 32'(exc_code), 32'h08);
    chk("sys_epc", exc_epc, 32'h00400100);
    chk("sys_vector", redirect_pc, 32'h00400004);
    chk("sys_flush", 32'(flush), 32'd1);
    chk("sys_redirect", 32'(redirect), 32'd1);
    is_syscall = 1'b0;
    tick();
    chk("sys_pulse_once", 32'(exc_req), 32'd0);
    chk("sys_in_handler", 32'(in_handler), 32'd1);
    tick();
    chk("sys_in_handler2", 32'(in_handler), 32'd1);
    do_eret("sys", 32'h00400100);
    chk("sys_eret_once", 32'(eret_req), 32'd0);

    // inst_valid=0 masks a syscall
    inst_valid = 1'b0; is_syscall = 1'b1;
    tick();
    chk("mask_invalid", 32'(exc_req), 32'd0);
    is_syscall = 1'b0; inst_valid = 1'b1;
    tick();

    // priority: all enabled -> syscall
    status = 32'hF; pc = 32'h00400200;
    is_syscall = 1'b1; is_break = 1'b1; is_teq = 1'b1; teq_eq = 1'b1;
    tick();
    chk("prio_all_code", 32'(exc_code), 32'h08);
    clr_dec(); tick();
    do_eret("prio_all", 32'h00400200);

    // syscall disabled -> break
    status = 32'hD;
    is_syscall = 1'b1; is_break = 1'b1; is_teq = 1'b1; teq_eq = 1'b1;
    tick();
    chk("prio_d_req", 32'(exc_req), 32'd1);
    chk("prio_d_code", 32'(exc_code), 32'h09);
    clr_dec(); tick();
    do_eret("prio_d", 32'h00400200);

    // only teq enabled -> trap
    status = 32'h9; pc = 32'h00400300;
    is_syscall = 1'b1; is_break = 1'b1; is_teq = 1'b1; teq_eq = 1'b1;
    tick();
    chk("prio_9_code", 32'(exc_code), 32'h0D);
    chk("prio_9_epc", exc_epc, 32'h00400300);
    clr_dec(); tick();
    do_eret("prio_9", 32'h00400300);

    // teq operands differ -> nothing taken
    is_syscall = 1'b1; is_break = 1'b1; is_teq = 1'b1; teq_eq = 1'b0;
    tick();
    chk("teq_ne_none", 32'(exc_req), 32'd0);
    chk("teq_ne_code_hold", 32'(exc_code), 32'h0D);
    clr_dec(); tick();

    // two irqs together: irq0 first, then irq1 after eret
    status = 32'h00000301; pc = 32'h00400400;
    irq = 6'b000011;
    tick(); tick();
    chk("irq_not_yet", 32'(irq_pending), 32'd0);
    tick();
    chk("irq_pending_11", 32'(irq_pending), 32'h3);
    chk("irq_no_req_yet", 32'(exc_req), 32'd0);
    tick();
    chk("irq0_req", 32'(exc_req), 32'd1);
    chk("irq0_code", 32'(exc_code), 32'h00);
    chk("irq0_epc", exc_epc, 32'h00400400);
    tick();
    chk("irq0_cleared", 32'(irq_pending), 32'h2);
    do_eret("irq0", 32'h00400400);
    tick();
    chk("irq1_req", 32'(exc_req), 32'd1);
    chk("irq1_code", 32'(exc_code), 32'h00);
    tick();
    chk("irq1_cleared", 32'(irq_pending), 32'h0);
    do_eret("irq1", 32'h00400400);

    // irq2 edge during HANDLER is deferred until after RET
    irq = '0; status = 32'h00000403;
    tick(); tick(); tick();
    is_syscall = 1'b1;
    tick();
    chk("h_sys_req", 32'(exc_req), 32'd1);
    is_syscall = 1'b0;
    tick();
    irq = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("h_no_nest", 32'(exc_req), 32'd0);
    end
    chk("h_irq2_pending", 32'(irq_pending), 32'h4);
    chk("h_still_handler", 32'(in_handler), 32'd1);
    do_eret("h", 32'h00400400);
    tick();
    chk("h_irq2_req", 32'(exc_req), 32'd1);
    chk("h_irq2_code", 32'(exc_code), 32'h00);
    tick();
    chk("h_irq2_cleared", 32'(irq_pending), 32'h0);
    do_eret("h2", 32'h00400400);

    // irq2 masked: stays pending, never taken
    irq = '0; status = 32'h00000003;
    tick(); tick(); tick();
    irq = 6'b000100;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("m_never_taken", 32'(exc_req), 32'd0);
    end
    chk("m_pending", 32'(irq_pending), 32'h4);

    // async reset during TAKE
    irq = '0;
    is_syscall = 1'b1;
    tick();
    chk("r_in_take", 32'(exc_req), 32'd1);
    is_syscall = 1'b0;
    rst = 1'b0;
    #1;
    chk("r_exc_req", 32'(exc_req), 32'd0);
    chk("r_flush", 32'(flush), 32'd0);
    chk("r_redirect", 32'(redirect), 32'd0);
    chk("r_code", 32'(exc_code), 32'd0);
    chk("r_pending", 32'(irq_pending), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("r_in_handler", 32'(in_handler), 32'd0);
    chk("r_pending_after", 32'(irq_pending), 32'd0);
    is_eret = 1'b1;
    tick();
    chk("r_eret_ignored", 32'(eret_req), 32'd0);
    chk("r_eret_no_flush", 32'(flush), 32'd0);
    is_eret = 1'b0;
    tick();
    chk("r_idle", 32'(in_handler), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
